weight_init_seq: RTL and testbench

//  Sequencer that owns the write/read port of the weight RAM (DW-bit signed words, WE=1 write,
//  WE=0 read with Q registered one clock later). On start it fills all DEPTH words with LFSR

---
 rtl/weight_init_seq.sv | 139 +++++++++++++
 tb/tb_weight_init_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_init_seq.sv
// weight_init_seq: owns the weight RAM port. A start pulse fills every word
// with LFSR pseudo-random weights; afterwards single-word reads are served
// with a fixed two-cycle accept-to-valid latency.
module weight_init_seq #(
    parameter int          DEPTH = 65,
    parameter int          DW    = 10,
    parameter int          AW    = 7,
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          SHIFT = 0
) (
    input  logic                 Clock,
    input  logic                 Rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 rd_req,
    input  logic [AW-1:0]        rd_addr,
    output logic                 rd_ready,
    output logic                 rd_valid,
    output logic signed [DW-1:0] rd_data,
    output logic                 rd_err,
    output logic signed [DW-1:0] ram_d,
    output logic [AW-1:0]        ram_addr,
    output logic                 ram_we,
    input  logic signed [DW-1:0] ram_q
);

    // A zero seed would lock the LFSR at zero forever, so it is swapped for the default.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    if (DW > 16) begin : g_dw_chk
        $error("weight_init_seq: DW must not exceed the 16-bit LFSR width");
    end
    if ((2 ** AW) < DEPTH) begin : g_aw_chk
        $error("weight_init_seq: AW too small to address DEPTH words");
    end
    if ((SHIFT < 0) || (SHIFT >= DW)) begin : g_shift_chk
        $error("weight_init_seq: SHIFT must lie in 0..DW-1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_READY,
        S_RD_ISSUE,
        S_RD_OUT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        lfsr;
    logic [AW-1:0]      wcnt;
    logic               addr_bad;
    logic               addr_bad_p1;
    logic               vld_p2;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left with the feedback bit entering at [0].
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Raw low bits are read as a signed word, then narrowed by an arithmetic shift.
    function automatic logic signed [DW-1:0] weight_of(input logic [DW-1:0] raw_bits);
        logic signed [DW-1:0] raw;
        raw = $signed(raw_bits);
        return raw >>> SHIFT;
    endfunction

    assign addr_bad = ({1'b0, rd_addr} >= DEPTH_W);

    // State register.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start wins over a same-cycle read in READY and is dropped mid-read.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_INIT;
            end
            S_INIT: begin
                if (wcnt == LAST_ADDR) state_nxt = S_READY;
            end
            S_READY: begin
                if (start)       state_nxt = S_INIT;
                else if (rd_req) state_nxt = S_RD_ISSUE;
            end
            S_RD_ISSUE: state_nxt = S_RD_OUT;
            S_RD_OUT:   state_nxt = S_READY;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // RAM port registers, write counter and LFSR; one LFSR step per word written.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            lfsr        <= SEED_EFF;
            wcnt        <= '0;
            ram_we      <= 1'b0;
            ram_d       <= '0;
            ram_addr    <= '0;
            addr_bad_p1 <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            if (state_nxt == S_INIT) begin
                // Write stage: the word leaving now uses the LFSR value before its advance.
                ram_we   <= 1'b1;
                ram_d    <= weight_of(lfsr[DW-1:0]);
                lfsr     <= lfsr_next(lfsr);
                ram_addr <= (state == S_INIT) ? wcnt + 1'b1 : '0;
                wcnt     <= (state == S_INIT) ? wcnt + 1'b1 : '0;
            end else if ((state == S_READY) && (state_nxt == S_RD_ISSUE)) begin
                // Issue stage: out-of-range addresses leave the RAM address untouched.
                if (!addr_bad) ram_addr <= rd_addr;
                addr_bad_p1 <= addr_bad;
            end
        end
    end

    // Outputs: status decoded from state; read data comes straight from the RAM's registered Q.
    always_comb begin
        busy     = (state == S_INIT);
        done     = (state == S_READY) || (state == S_RD_ISSUE) || (state == S_RD_OUT);
        rd_ready = (state == S_READY);
        vld_p2   = (state == S_RD_OUT);
        rd_valid = vld_p2;
        rd_err   = vld_p2 & addr_bad_p1;
        rd_data  = (vld_p2 && !addr_bad_p1) ? ram_q : '0;
    end

endmodule

// File: tb/tb_weight_init_seq.sv
// Bench for weight_init_seq: a behavioural RAM, an LFSR reference model and
// write/read scoreboards fed when stimulus is driven and drained by a monitor.
module tb_weight_init_seq;

    localparam int          DEPTH = 65;
    localparam int          DW    = 10;
    localparam int          AW    = 7;
    localparam logic [15:0] SEED  = 16'hACE1;

    typedef struct {
        int                   cyc;
        logic [AW-1:0]        addr;
        logic signed [DW-1:0] data;
    } wr_t;

    typedef struct {
        int                   cyc;
        logic signed [DW-1:0] data;
        logic                 err;
    } rd_t;

    logic                 Clock;
    logic                 Rst;
    logic                 start;
    logic                 busy, done, rd_req, rd_ready, rd_valid, rd_err, ram_we;
    logic [AW-1:0]        rd_addr, ram_addr;
    logic signed [DW-1:0] rd_data, ram_d, ram_q;

    logic                 busy3, done3, rd_ready3, rd_valid3, rd_err3, ram_we3;
    logic                 rd_req3;
    logic [AW-1:0]        rd_addr3, ram_addr3;
    logic signed [DW-1:0] rd_data3, ram_d3, ram_q3;

    logic signed [DW-1:0] mem [0:(2**AW)-1];
    logic signed [DW-1:0] exp_mem [0:(2**AW)-1];
    logic [15:0]          m_lfsr;

    wr_t                  wq[$];
    rd_t                  rq[$];
    wr_t                  we_e;
    rd_t                  re_e;

    int                   cyc = 0;
    int                   n_tests = 0;
    int                   n_fail = 0;
    int                   n_valid = 0;
    logic signed [DW-1:0] last_w0;
    logic signed [DW-1:0] first_w0;
    logic signed [DW-1:0] last_rd_data;

    weight_init_seq #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .SEED(SEED), .SHIFT(0)) dut (
        .Clock(Clock), .Rst(Rst), .start(start), .busy(busy), .done(done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_err(rd_err), .ram_d(ram_d), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_q(ram_q)
    );

    weight_init_seq #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .SEED(SEED), .SHIFT(3)) dut3 (
        .Clock(Clock), .Rst(Rst), .start(start), .busy(busy3), .done(done3),
        .rd_req(rd_req3), .rd_addr(rd_addr3), .rd_ready(rd_ready3), .rd_valid(rd_valid3),
        .rd_data(rd_data3), .rd_err(rd_err3), .ram_d(ram_d3), .ram_addr(ram_addr3),
        .ram_we(ram_we3), .ram_q(ram_q3)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign rd_req3  = 1'b0;
    assign rd_addr3 = '0;
    assign ram_q3   = '0;

    always @(posedge Clock) cyc <= cyc + 1;

    // Behavioural weight RAM, cleared by the shared reset, Q registered one clock after the address.
    always @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
            ram_q <= '0;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_d;
        end else begin
            ram_q <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic signed [DW-1:0] mk_weight(input logic [15:0] v);
        logic signed [DW-1:0] r;
        r = v[DW-1:0];
        return r;
    endfunction

    // Monitor: drains the scoreboards as the DUT writes the RAM or returns read data.
    always @(negedge Clock) begin
        if (Rst) begin
            if (ram_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 32'(ram_addr), 32'hFFFF_FFFF);
                end else begin
                    we_e = wq.pop_front();
                    chk("wr_cycle", 32'(cyc), 32'(we_e.cyc));
                    chk("wr_addr", 32'(ram_addr), 32'(we_e.addr));
                    chk("wr_data", 32'(ram_d), 32'(we_e.data));
                    if (we_e.addr == '0) last_w0 = ram_d;
                end
            end
            if (rd_valid) begin
                n_valid++;
                last_rd_data = rd_data;
                if (rq.size() == 0) begin
                    chk("unexpected_rd_valid", 32'(rd_data), 32'hFFFF_FFFF);
                end else begin
                    re_e = rq.pop_front();
                    chk("rd_cycle", 32'(cyc), 32'(re_e.cyc));
                    chk("rd_data", 32'(rd_data), 32'(re_e.data));
                    chk("rd_err", 32'(rd_err), 32'(re_e.err));
                end
            end
            if (ram_we3) begin
                chk("shift3_range", 32'((ram_d3 >= -64) && (ram_d3 <= 63)), 32'd1);
            end
        end
    end

    task automatic push_init();
        wr_t e;
        for (int k = 0; k < DEPTH; k++) begin
            e.cyc  = cyc + 1 + k;
            e.addr = AW'(k);
            e.data = mk_weight(m_lfsr);
            exp_mem[k] = e.data;
            m_lfsr = lfsr_step(m_lfsr);
            wq.push_back(e);
        end
    endtask

    // Drive one cycle of inputs; expected results go on the scoreboards at the moment of driving.
    task automatic cyc_drive(input logic s, input logic rq_in, input logic [AW-1:0] a,
                             input logic expect_init);
        rd_t r;
        start   = s;
        rd_req  = rq_in;
        rd_addr = a;
        if (rq_in && rd_ready && !s) begin
            r.cyc  = cyc + 2;
            r.err  = (int'(a) >= DEPTH);
            r.data = r.err ? '0 : exp_mem[a];
            rq.push_back(r);
        end
        if (s && expect_init) push_init();
        @(negedge Clock);
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_busy"},     32'(busy),     0);
        chk({pfx, "_done"},     32'(done),     0);
        chk({pfx, "_rd_ready"}, 32'(rd_ready), 0);
        chk({pfx, "_rd_valid"}, 32'(rd_valid), 0);
        chk({pfx, "_rd_err"},   32'(rd_err),   0);
        chk({pfx, "_rd_data"},  32'(rd_data),  0);
        chk({pfx, "_ram_we"},   32'(ram_we),   0);
        chk({pfx, "_ram_d"},    32'(ram_d),    0);
        chk({pfx, "_ram_addr"}, 32'(ram_addr), 0);
    endtask

    task automatic do_init(input string pfx, input logic with_rd);
        cyc_drive(1'b1, with_rd, AW'(3), 1'b1);
        chk({pfx, "_busy_t1"},  32'(busy),     1);
        chk({pfx, "_done_t1"},  32'(done),     0);
        chk({pfx, "_ready_t1"}, 32'(rd_ready), 0);
        repeat (DEPTH) cyc_drive(1'b0, 1'b0, '0, 1'b0);
        chk({pfx, "_busy_end"},  32'(busy),      0);
        chk({pfx, "_done_end"},  32'(done),      1);
        chk({pfx, "_ready_end"}, 32'(rd_ready),  1);
        chk({pfx, "_we_end"},    32'(ram_we),    0);
        chk({pfx, "_writes_left"}, 32'(wq.size()), 0);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        int n;
        n = 0;
        while (!rd_ready && n < 20) begin
            cyc_drive(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        if (!rd_ready) begin
            chk("rd_ready_timeout", 32'(rd_ready), 1);
        end else begin
            cyc_drive(1'b0, 1'b1, a, 1'b0);
            chk("rd_issue_we", 32'(ram_we), 0);
            chk("rd_issue_ready", 32'(rd_ready), 0);
            if (int'(a) < DEPTH) chk("rd_issue_addr", 32'(ram_addr), 32'(a));
            cyc_drive(1'b0, 1'b0, '0, 1'b0);
            cyc_drive(1'b0, 1'b0, '0, 1'b0);
            chk("rd_back_ready", 32'(rd_ready), 1);
            chk("rd_drain", 32'(rq.size()), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0;
        Rst     = 1'b0;
        start   = 1'b0;
        rd_req  = 1'b0;
        rd_addr = '0;
        m_lfsr  = SEED;
        for (int i = 0; i < 2**AW; i++) exp_mem[i] = '0;
        repeat (3) @(negedge Clock);
        check_reset_vals("in_rst");
        Rst = 1'b1;
        @(negedge Clock);
        check_reset_vals("rst_rel");

        // Reads are refused while idle.
        v0 = n_valid;
        repeat (10) cyc_drive(1'b0, 1'b1, AW'(5), 1'b0);
        chk("idle_rd_valid_count", 32'(n_valid - v0), 0);
        chk("idle_rd_ready", 32'(rd_ready), 0);
        chk("idle_busy", 32'(busy), 0);
        cyc_drive(1'b0, 1'b0, '0, 1'b0);

        // First fill and reads, including out-of-range addresses.
        do_init("init1", 1'b0);
        chk("w0_225", 32'(last_w0), 32'd225);
        first_w0 = last_w0;
        do_read(AW'(0));
        chk("rd0_225", 32'(last_rd_data), 32'd225);
        do_read(AW'(64));
        do_read(AW'(100));
        do_read(AW'(127));
        do_read(AW'(65));
        do_read(AW'(17));
        for (int i = 0; i < 4; i++) do_read(AW'($urandom_range(0, DEPTH - 1)));

        // start beats a same-cycle rd_req; the refill continues the LFSR sequence.
        v0 = n_valid;
        do_init("init2", 1'b1);
        chk("sim_no_rd_valid", 32'(n_valid - v0), 0);
        chk("reinit_w0_is_new", 32'(last_w0 == first_w0), 0);
        do_read(AW'(0));
        do_read(AW'(64));
        do_read(AW'(33));

        // start while a read is in flight is dropped.
        cyc_drive(1'b0, 1'b1, AW'(9), 1'b0);
        cyc_drive(1'b1, 1'b0, '0, 1'b0);
        cyc_drive(1'b0, 1'b0, '0, 1'b0);
        cyc_drive(1'b0, 1'b0, '0, 1'b0);
        chk("drop_busy", 32'(busy), 0);
        chk("drop_ready", 32'(rd_ready), 1);
        chk("drop_rd_drain", 32'(rq.size()), 0);
        do_read(AW'(9));

        // Reset while write 30 of a fill is on the RAM port.
        repeat (DEPTH + 2) cyc_drive(1'b0, 1'b0, '0, 1'b0);
        cyc_drive(1'b1, 1'b0, '0, 1'b1);
        repeat (30) cyc_drive(1'b0, 1'b0, '0, 1'b0);
        chk("midrst_addr_before", 32'(ram_addr), 30);
        Rst = 1'b0;
        wq.delete();
        rq.delete();
        m_lfsr = SEED;
        for (int i = 0; i < 2**AW; i++) exp_mem[i] = '0;
        @(negedge Clock);
        check_reset_vals("midrst");
        Rst = 1'b1;
        @(negedge Clock);
        chk("midrst_done_after", 32'(done), 0);
        do_init("init3", 1'b0);
        chk("init3_w0_225", 32'(last_w0), 32'd225);
        do_read(AW'(64));
        do_read(AW'(30));
        do_read(AW'(0));
        chk("init3_rd0_225", 32'(last_rd_data), 32'd225);
        repeat (DEPTH + 2) cyc_drive(1'b0, 1'b0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
